// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmitter.
// Holds the FSM state enum, common command bytes and the parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_WAIT_CLK,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_ERR
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus registered falling-edge detect for one PS/2 line.
// Ports: clock, reset_n (sync, active low), pin (raw), level (synced), fall (pulse).
module ps2_line_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Idle PS/2 lines sit high, so reset the chain to 1 to avoid a fake edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
            fall <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
            fall <= prev & ~sync;
        end
    end

    assign level = sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, shift, ACK check).
// Ports: clock, reset_n, tx_data/tx_valid/tx_ready handshake, busy, tx_done,
// tx_error pulses, raw ps2_clk/ps2_data inputs, open-drain ps2_clk_oe/ps2_dat_oe.
// Optional macro PS2_TX_RETRY_EN: retry a failed frame up to MAX_RETRIES times.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
    parameter int unsigned INHIBIT_US       = 100,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned FRAME_TIMEOUT_US = 2000
`ifdef PS2_TX_RETRY_EN
    ,
    parameter int unsigned MAX_RETRIES      = 2
`endif
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned CYC_US    = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned INH_CNT   = CYC_US * INHIBIT_US;
    localparam int unsigned START_CNT = CYC_US * START_TIMEOUT_US;
    localparam int unsigned FRAME_CNT = CYC_US * FRAME_TIMEOUT_US;
    localparam int unsigned MAX_A     = (INH_CNT > START_CNT) ? INH_CNT : START_CNT;
    localparam int unsigned MAX_CNT   = (MAX_A > FRAME_CNT) ? MAX_A : FRAME_CNT;
    localparam int unsigned TW        = $clog2(MAX_CNT);

    localparam logic [TW-1:0] INH_LD   = TW'(INH_CNT - 1);
    // One cycle in REQ and one in ERR, so tx_error lands START_CNT
    // cycles after the clock line is released.
    localparam logic [TW-1:0] START_LD = TW'(START_CNT - 2);
    localparam logic [TW-1:0] FRAME_LD = TW'(FRAME_CNT - 1);

    ps2_tx_state_t state;
    logic [TW-1:0] timer;
    logic [3:0]    n;
    logic [3:0]    nxt;
    logic [7:0]    data_q;
    logic          par_q;
    logic [9:0]    frame_bits;

    logic clk_level;
    logic clk_fall;
    logic dat_level;
    logic dat_fall_unused;

`ifdef PS2_TX_RETRY_EN
    localparam int unsigned RW = $clog2(MAX_RETRIES + 2);
    logic [RW-1:0] retries;
`endif

    ps2_line_sync u_clk_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .pin    (ps2_clk),
        .level  (clk_level),
        .fall   (clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .pin    (ps2_data),
        .level  (dat_level),
        .fall   (dat_fall_unused)
    );

    // Bit 9 is the stop bit: driving ~1 releases the line.
    assign frame_bits = {1'b1, par_q, data_q};
    assign nxt        = n + 4'd1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            timer      <= '0;
            n          <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retries    <= '0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        data_q     <= tx_data;
                        par_q      <= odd_parity(tx_data);
                        busy       <= 1'b1;
                        tx_ready   <= 1'b0;
                        ps2_clk_oe <= 1'b1;
                        timer      <= INH_LD;
                        state      <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                        retries    <= '0;
`endif
                    end
                end
                ST_INHIBIT: begin
                    if (timer == TW'(1))
                        ps2_dat_oe <= 1'b1;
                    if (timer == '0) begin
                        ps2_clk_oe <= 1'b0;
                        timer      <= START_LD;
                        state      <= ST_REQ;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_REQ: begin
                    timer <= timer - 1'b1;
                    state <= ST_WAIT_CLK;
                end
                ST_WAIT_CLK: begin
                    if (clk_fall) begin
                        ps2_dat_oe <= ~frame_bits[0];
                        n          <= '0;
                        timer      <= FRAME_LD;
                        state      <= ST_SHIFT;
                    end else if (timer == '0) begin
                        ps2_dat_oe <= 1'b0;
                        state      <= ST_ERR;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (timer == '0) begin
                        ps2_dat_oe <= 1'b0;
                        state      <= ST_ERR;
                    end else begin
                        timer <= timer - 1'b1;
                        if (clk_fall) begin
                            n          <= nxt;
                            ps2_dat_oe <= ~frame_bits[nxt];
                            if (n == 4'd8)
                                state <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (timer == '0) begin
                        state <= ST_ERR;
                    end else begin
                        timer <= timer - 1'b1;
                        if (clk_fall)
                            state <= dat_level ? ST_ERR : ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (timer == '0) begin
                        state <= ST_ERR;
                    end else if (clk_level && dat_level) begin
                        tx_done  <= 1'b1;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_ERR: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                    if (retries < RW'(MAX_RETRIES)) begin
                        retries    <= retries + 1'b1;
                        ps2_clk_oe <= 1'b1;
                        timer      <= INH_LD;
                        state      <= ST_INHIBIT;
                    end else begin
                        tx_error <= 1'b1;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
`else
                    tx_error <= 1'b1;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    state    <= ST_IDLE;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model.
// Runs at 2 MHz so inhibit is 200 cycles, start timeout 30000, frame 4000.
module tb_ps2_host_tx;

    localparam int INH_EXP   = 200;
    localparam int START_EXP = 30000;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       dev_clk_low;
    logic       dev_dat_low;
    logic       ps2_clk_line;
    logic       ps2_data_line;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int inh_cnt  = 0;
    logic clk_oe_q = 1'b0;

    assign ps2_clk_line  = !(ps2_clk_oe || dev_clk_low);
    assign ps2_data_line = !(ps2_dat_oe || dev_dat_low);

    always #10 clock = ~clock;

    ps2_host_tx #(
        .CLK_FREQ_HZ(2_000_000)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .ps2_clk   (ps2_clk_line),
        .ps2_data  (ps2_data_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always @(negedge clock) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
        if (ps2_clk_oe === 1'b1 && clk_oe_q !== 1'b1) inh_cnt <= inh_cnt + 1;
        clk_oe_q <= ps2_clk_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    // Wait for an inhibit phase, then count its length until release.
    task automatic wait_release(output int inh, output int dfirst);
        int g = 0;
        inh    = 0;
        dfirst = 0;
        while (ps2_clk_oe !== 1'b1 && g < 10000) begin
            @(negedge clock);
            g++;
        end
        while (ps2_clk_oe === 1'b1 && inh < 100000) begin
            inh++;
            if (ps2_dat_oe === 1'b1 && dfirst == 0) dfirst = inh;
            @(negedge clock);
        end
    endtask

    // Device model: host data is sampled while the clock is low, just
    // before the rising edge. Fall 11 is the ACK slot.
    task automatic dev_frame(input int nfalls, input bit ack,
                             output logic [9:0] bits);
        bits = '0;
        repeat (50) @(negedge clock);
        for (int i = 0; i < nfalls; i++) begin
            if (i == 10 && ack) begin
                dev_dat_low = 1'b1;
                repeat (5) @(negedge clock);
            end
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clock);
            if (i < 10) bits[i] = ps2_data_line;
            dev_clk_low = 1'b0;
            repeat (20) @(negedge clock);
        end
        dev_dat_low = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic wait_cnt_done(input int target);
        int g = 0;
        while (done_cnt < target && g < 10000) begin
            @(negedge clock);
            g++;
        end
    endtask

    initial begin
        int inh;
        int dfirst;
        int cyc;
        int d0;
        int e0;
        int i0;
        logic [9:0] bits;

        reset_n     = 1'b0;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_tx_error", 32'(tx_error), 32'd0);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);

        // 0xED, full frame with ACK
        send(8'hED);
        chk("ed_busy", 32'(busy), 32'd1);
        wait_release(inh, dfirst);
        chk("ed_inhibit_len", 32'(inh), 32'(INH_EXP));
        chk("ed_dat_oe_first", 32'(dfirst), 32'(INH_EXP));
        chk("ed_start_bit", 32'(ps2_dat_oe), 32'd1);
        dev_frame(11, 1'b1, bits);
        wait_cnt_done(1);
        chk("ed_data", 32'(bits[7:0]), 32'hED);
        chk("ed_parity", 32'(bits[8]), 32'd1);
        chk("ed_stop", 32'(bits[9]), 32'd1);
        chk("ed_done_cnt", 32'(done_cnt), 32'd1);
        chk("ed_err_cnt", 32'(err_cnt), 32'd0);
        chk("ed_ready", 32'(tx_ready), 32'd1);

`ifndef PS2_TX_RETRY_EN
        // Device never clocks
        e0 = err_cnt;
        send(8'hF4);
        wait_release(inh, dfirst);
        cyc = 0;
        while (tx_error !== 1'b1 && cyc < START_EXP + 1000) begin
            @(negedge clock);
            cyc++;
        end
        chk("to_cycles", 32'(cyc), 32'(START_EXP));
        chk("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("to_dat_oe", 32'(ps2_dat_oe), 32'd0);
        @(negedge clock);
        chk("to_ready", 32'(tx_ready), 32'd1);
        chk("to_err_cnt", 32'(err_cnt), 32'(e0 + 1));
`endif

        // Missing ACK
        d0 = done_cnt;
        e0 = err_cnt;
        i0 = inh_cnt;
        send(8'hED);
`ifdef PS2_TX_RETRY_EN
        for (int a = 0; a < 3; a++) begin
            wait_release(inh, dfirst);
            dev_frame(11, 1'b0, bits);
        end
        repeat (10) @(negedge clock);
        chk("nack_inhibits", 32'(inh_cnt - i0), 32'd3);
`else
        wait_release(inh, dfirst);
        dev_frame(11, 1'b0, bits);
        repeat (10) @(negedge clock);
        chk("nack_inhibits", 32'(inh_cnt - i0), 32'd1);
`endif
        chk("nack_err", 32'(err_cnt - e0), 32'd1);
        chk("nack_done", 32'(done_cnt - d0), 32'd0);

        // Reset after the 4th data bit
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h55);
        wait_release(inh, dfirst);
        dev_frame(4, 1'b0, bits);
        reset_n = 1'b0;
        @(negedge clock);
        chk("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("mid_rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        chk("mid_rst_ready", 32'(tx_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("mid_rst_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        // Back-to-back 0xFF then 0x01, second request held while busy
        d0 = done_cnt;
        @(negedge clock);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_data = 8'h01;
        chk("b2b_ready_busy", 32'(tx_ready), 32'd0);
        wait_release(inh, dfirst);
        dev_frame(11, 1'b1, bits);
        chk("b2b_ff_data", 32'(bits[7:0]), 32'hFF);
        chk("b2b_ff_parity", 32'(bits[8]), 32'd1);
        cyc = 0;
        while (ps2_clk_oe !== 1'b1 && cyc < 10000) begin
            @(negedge clock);
            cyc++;
        end
        chk("b2b_done_before_2nd", 32'(done_cnt - d0), 32'd1);
        tx_valid = 1'b0;
        wait_release(inh, dfirst);
        dev_frame(11, 1'b1, bits);
        wait_cnt_done(d0 + 2);
        chk("b2b_01_data", 32'(bits[7:0]), 32'h01);
        chk("b2b_01_parity", 32'(bits[8]), 32'd0);
        chk("b2b_done_total", 32'(done_cnt - d0), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
